// File: rtl/intrp_pkg.sv
// Shared types and width helpers for the interpolator frame assembler.
package intrp_pkg;

  typedef enum logic [0:0] {
    ASM_SYNC    = 1'b0,
    ASM_COLLECT = 1'b1
  } asm_state_e;

  // A single-channel frame still needs a one-bit channel tag.
  function automatic int calc_chw(input int nr_channels);
    return (nr_channels > 1) ? $clog2(nr_channels) : 1;
  endfunction

  function automatic int calc_lvlw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through frame FIFO with a registered head word, valid, ready and level.
module sync_fifo_fwft
  import intrp_pkg::*;
#(
  parameter  int WIDTH = 72,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVLW  = calc_lvlw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [LVLW-1:0]  level_o
);

  localparam logic [AW:0]     PTR_ONE  = (AW+1)'(1);
  localparam logic [LVLW-1:0] LVL_ONE  = LVLW'(1);
  localparam logic [LVLW-1:0] LVL_FULL = LVLW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0]  level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, ready_q;
  logic             wr_ok, rd_ok;

  assign wr_ok = wr_en_i && ready_q;
  assign rd_ok = rd_en_i && valid_q;

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // The incoming word becomes the head when it lands in the slot the read pointer will address.
    dout_d = mem_q[rd_ptr_d[AW-1:0]];
    if (wr_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      dout_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      valid_q  <= (level_d != '0);
      ready_q  <= (level_d < LVL_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign wr_ready_o = ready_q;
  assign rd_data_o  = dout_q;
  assign rd_valid_o = valid_q;
  assign level_o    = level_q;

endmodule

// File: rtl/intrp_frame_fifo.sv
// Packs the interleaved interpolator stream into whole frames and buffers them for the consumer.
// state       | meaning
// ASM_SYNC    | waiting for a channel-0 sample; other channels are discarded
// ASM_COLLECT | filling slot exp_ch of the staged frame
module intrp_frame_fifo
  import intrp_pkg::*;
#(
  parameter  int NR_CHANNELS = 3,
  parameter  int INPUT_WIDTH = 24,
  parameter  int DEPTH       = 16,
  localparam int CHW         = calc_chw(NR_CHANNELS),
  localparam int LVLW        = calc_lvlw(DEPTH),
  localparam int FW          = NR_CHANNELS * INPUT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] s_frm_d,
  input  logic [CHW-1:0]         s_frm_ch,
  input  logic                   s_frm_dv,
  output logic                   s_frm_dr,
  output logic [FW-1:0]          m_frm_d,
  output logic                   m_frm_dv,
  input  logic                   m_frm_dr,
  output logic [LVLW-1:0]        level,
  output logic                   ch_error
);

  localparam logic [CHW-1:0] LAST_CH  = CHW'(NR_CHANNELS - 1);
  localparam logic [CHW-1:0] CH_ONE   = CHW'(1);
  localparam logic [CHW-1:0] FIRST_EX = (NR_CHANNELS == 1) ? '0 : CH_ONE;

  asm_state_e       state_q, state_d;
  logic [CHW-1:0]   exp_ch_q, exp_ch_d;
  logic [FW-1:0]    stage_q, stage_d;
  logic [FW-1:0]    frame_w;
  logic             err_q, err_d;
  logic             acc;
  logic             wr_en;

  assign acc = s_frm_dv && s_frm_dr;

  always_comb begin
    frame_w = stage_q;
    frame_w[slot_lsb(NR_CHANNELS - 1, INPUT_WIDTH) +: INPUT_WIDTH] = s_frm_d;
  end

  always_comb begin
    state_d  = state_q;
    exp_ch_d = exp_ch_q;
    stage_d  = stage_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    if (acc) begin
      unique case (state_q)
        ASM_SYNC: begin
          if (s_frm_ch == '0) begin
            stage_d[slot_lsb(0, INPUT_WIDTH) +: INPUT_WIDTH] = s_frm_d;
            state_d  = ASM_COLLECT;
            exp_ch_d = FIRST_EX;
            wr_en    = (NR_CHANNELS == 1);
          end
        end
        ASM_COLLECT: begin
          if (s_frm_ch == exp_ch_q) begin
            stage_d[slot_lsb(int'(exp_ch_q), INPUT_WIDTH) +: INPUT_WIDTH] = s_frm_d;
            if (exp_ch_q == LAST_CH) begin
              wr_en    = 1'b1;
              exp_ch_d = '0;
            end else begin
              exp_ch_d = exp_ch_q + CH_ONE;
            end
          end else begin
            // Out-of-order sample: drop the partial frame, resync on channel 0 if possible.
            err_d = 1'b1;
            if (s_frm_ch == '0) begin
              stage_d[slot_lsb(0, INPUT_WIDTH) +: INPUT_WIDTH] = s_frm_d;
              exp_ch_d = FIRST_EX;
            end else begin
              state_d  = ASM_SYNC;
              exp_ch_d = '0;
            end
          end
        end
        default: state_d = ASM_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ASM_SYNC;
      exp_ch_q <= '0;
      stage_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_ch_q <= exp_ch_d;
      stage_q  <= stage_d;
      err_q    <= err_d;
    end
  end

  assign ch_error = err_q;

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (frame_w),
    .wr_ready_o (s_frm_dr),
    .rd_en_i    (m_frm_dr),
    .rd_data_o  (m_frm_d),
    .rd_valid_o (m_frm_dv),
    .level_o    (level)
  );

endmodule

// File: tb/tb_intrp_frame_fifo.sv
// Directed and randomised checks of frame assembly, FIFO flow control and reset for intrp_frame_fifo.
module tb_intrp_frame_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_frm_d;
  logic [1:0]  s_frm_ch;
  logic        s_frm_dv;
  logic        s_frm_dr;
  logic [71:0] m_frm_d;
  logic        m_frm_dv;
  logic        m_frm_dr;
  logic [4:0]  level;
  logic        ch_error;

  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          err_seen = 0;
  logic        rand_dr = 1'b0;
  logic [71:0] exp_q [$];

  intrp_frame_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .s_frm_d  (s_frm_d),
    .s_frm_ch (s_frm_ch),
    .s_frm_dv (s_frm_dv),
    .s_frm_dr (s_frm_dr),
    .m_frm_d  (m_frm_d),
    .m_frm_dv (m_frm_dv),
    .m_frm_dr (m_frm_dr),
    .level    (level),
    .ch_error (ch_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk_frame(input logic [23:0] d0, input logic [23:0] d1,
                                            input logic [23:0] d2);
    return {d2, d1, d0};
  endfunction

  // One clock: consume a frame if handshaking, cross the edge, sample #1 after it.
  task automatic tick();
    logic [71:0] exp;
    if (rand_dr) m_frm_dr = 1'($urandom_range(0, 1));
    if (m_frm_dv && m_frm_dr) begin
      chk("frame_expected", 72'(exp_q.size() != 0), 72'(1));
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        chk("frame_data", m_frm_d, exp);
      end
      pops++;
    end
    @(posedge clk);
    #1;
    if (ch_error === 1'b1) err_seen++;
  endtask

  task automatic send(input logic [1:0] ch, input logic [23:0] d);
    logic acc;
    acc = 1'b0;
    s_frm_dv = 1'b1;
    s_frm_ch = ch;
    s_frm_d  = d;
    for (int i = 0; i < 400 && !acc; i++) begin
      acc = s_frm_dr;
      tick();
    end
    if (!acc) chk("send_timeout", 72'(acc), 72'(1));
  endtask

  task automatic drain();
    s_frm_dv = 1'b0;
    for (int i = 0; i < 4000 && (m_frm_dv || exp_q.size() != 0); i++) tick();
    chk("drain_sb_empty", 72'(exp_q.size()), 72'(0));
    chk("drain_level", 72'(level), 72'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_frm_dv = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int          p0, e0;
    logic [23:0] a, b, c;
    rst = 1'b1;
    s_frm_dv = 1'b0;
    s_frm_ch = '0;
    s_frm_d  = '0;
    m_frm_dr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_s_frm_dr", 72'(s_frm_dr), 72'(0));
    chk("rst_m_frm_dv", 72'(m_frm_dv), 72'(0));
    chk("rst_m_frm_d", m_frm_d, 72'(0));
    chk("rst_level", 72'(level), 72'(0));
    chk("rst_ch_error", 72'(ch_error), 72'(0));
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 72'(s_frm_dr), 72'(1));

    // basic frame and one-cycle latency
    m_frm_dr = 1'b1;
    exp_q.push_back(mk_frame(24'h100001, 24'h200002, 24'h300003));
    send(2'd0, 24'h100001);
    send(2'd1, 24'h200002);
    chk("no_early_dv", 72'(m_frm_dv), 72'(0));
    send(2'd2, 24'h300003);
    chk("lat_dv", 72'(m_frm_dv), 72'(1));
    chk("lat_data", m_frm_d, 72'h300003_200002_100001);
    chk("lat_level", 72'(level), 72'(1));
    s_frm_dv = 1'b0;
    tick();
    chk("basic_level0", 72'(level), 72'(0));
    chk("basic_dv0", 72'(m_frm_dv), 72'(0));

    // fill to capacity with consumer stalled
    m_frm_dr = 1'b0;
    for (int f = 0; f < 16; f++) begin
      a = {8'hA0, 8'(f), 8'h00};
      b = {8'hA1, 8'(f), 8'h01};
      c = {8'hA2, 8'(f), 8'h02};
      exp_q.push_back(mk_frame(a, b, c));
      send(2'd0, a);
      send(2'd1, b);
      send(2'd2, c);
    end
    chk("full_level", 72'(level), 72'(16));
    chk("full_not_ready", 72'(s_frm_dr), 72'(0));
    s_frm_dv = 1'b1;
    s_frm_ch = 2'd0;
    s_frm_d  = 24'hDEAD00;
    for (int i = 0; i < 3; i++) tick();
    chk("full_blocked_level", 72'(level), 72'(16));
    chk("full_blocked_ready", 72'(s_frm_dr), 72'(0));
    s_frm_dv = 1'b0;
    m_frm_dr = 1'b1;
    tick();
    chk("pop1_level", 72'(level), 72'(15));
    chk("pop1_ready", 72'(s_frm_dr), 72'(1));
    drain();

    // sequence error: 0,1,0,1,2
    p0 = pops;
    e0 = err_seen;
    exp_q.push_back(mk_frame(24'h0B0000, 24'h0B0001, 24'h0B0002));
    send(2'd0, 24'h0A0000);
    send(2'd1, 24'h0A0001);
    send(2'd0, 24'h0B0000);
    chk("err_pulse_now", 72'(ch_error), 72'(1));
    send(2'd1, 24'h0B0001);
    chk("err_pulse_gone", 72'(ch_error), 72'(0));
    send(2'd2, 24'h0B0002);
    drain();
    chk("err_count", 72'(err_seen - e0), 72'(1));
    chk("err_frames", 72'(pops - p0), 72'(1));

    // SYNC discards leading non-zero channels
    do_reset();
    p0 = pops;
    e0 = err_seen;
    exp_q.push_back(mk_frame(24'h0C0000, 24'h0C0001, 24'h0C0002));
    send(2'd1, 24'h0D0001);
    send(2'd2, 24'h0D0002);
    send(2'd0, 24'h0C0000);
    send(2'd1, 24'h0C0001);
    send(2'd2, 24'h0C0002);
    drain();
    chk("sync_no_err", 72'(err_seen - e0), 72'(0));
    chk("sync_frames", 72'(pops - p0), 72'(1));

    // random consumer backpressure
    p0 = pops;
    e0 = err_seen;
    rand_dr = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      c = 24'($urandom);
      exp_q.push_back(mk_frame(a, b, c));
      send(2'd0, a);
      send(2'd1, b);
      send(2'd2, c);
    end
    drain();
    rand_dr = 1'b0;
    chk("rand_frames", 72'(pops - p0), 72'(1000));
    chk("rand_no_err", 72'(err_seen - e0), 72'(0));

    // reset with frames buffered and a partial frame staged
    m_frm_dr = 1'b0;
    for (int f = 0; f < 5; f++) begin
      send(2'd0, 24'h111100 + 24'(f));
      send(2'd1, 24'h222200 + 24'(f));
      send(2'd2, 24'h333300 + 24'(f));
    end
    send(2'd0, 24'h444400);
    send(2'd1, 24'h444401);
    chk("pre_rst_level", 72'(level), 72'(5));
    s_frm_dv = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_rst_level", 72'(level), 72'(0));
    chk("mid_rst_dv", 72'(m_frm_dv), 72'(0));
    chk("mid_rst_ready", 72'(s_frm_dr), 72'(0));
    @(posedge clk);
    #1;
    chk("held_rst_ready", 72'(s_frm_dr), 72'(0));
    rst = 1'b0;
    p0 = pops;
    m_frm_dr = 1'b1;
    exp_q.push_back(mk_frame(24'h555500, 24'h555501, 24'h555502));
    send(2'd0, 24'h555500);
    send(2'd1, 24'h555501);
    send(2'd2, 24'h555502);
    drain();
    chk("post_rst_frames", 72'(pops - p0), 72'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intrp_frame_fifo.md
# intrp_frame_fifo

Frame assembler and elastic buffer downstream of the interpolator. It accepts the interpolator's channel-interleaved output stream, one sample per handshake tagged with a channel number. It packs channels 0..NR_CHANNELS-1 into one frame word and buffers complete frames in a first-word-fall-through FIFO. The consumer, a serializer or DAC interface, then reads whole frames at its own pace.

## Interface
- NR_CHANNELS, 3, channels per frame (≥1)
- INPUT_WIDTH, 24, sample width in bits
- DEPTH, 16, FIFO capacity in frames (power of 2, ≥2)
- Derived: CHW = max(1, $clog2(NR_CHANNELS)); LVLW = $clog2(DEPTH)+1

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s_frm_d  in  INPUT_WIDTH  sample from interpolator m_intrp_d
- s_frm_ch  in  CHW  channel tag from m_intrp_ch
- s_frm_dv  in  1  sample valid
- s_frm_dr  out  1  ready; drives interpolator m_intrp_dr
- m_frm_d  out  NR_CHANNELS*INPUT_WIDTH  frame; channel k occupies bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- m_frm_dv  out  1  frame valid
- m_frm_dr  in  1  consumer ready
- level  out  LVLW  frames stored, 0..DEPTH
- ch_error  out  1  one-cycle pulse on channel sequence violation

## Operation
- A sample transfers when s_frm_dv && s_frm_dr. A frame transfers when m_frm_dv && m_frm_dr.
- Assembly FSM, two states:
  - SYNC (entered on reset): accepted samples with ch≠0 are discarded silently. An accepted ch=0 sample is stored in slot 0, sets exp_ch=1, and moves the FSM to COLLECT.
    - If NR_CHANNELS=1, that ch=0 sample completes the frame immediately.
  - COLLECT, accepted sample with ch==exp_ch: stored in slot exp_ch. If exp_ch==NR_CHANNELS-1, the staged frame plus this sample is written to the FIFO and exp_ch←0 (stay in COLLECT). Otherwise exp_ch←exp_ch+1.
  - COLLECT, accepted sample with ch≠exp_ch: the partial frame is dropped and ch_error pulses.
    - If ch==0, the sample starts a new frame in slot 0 and exp_ch←1.
    - Otherwise the FSM goes to SYNC.
- s_frm_dr = (level < DEPTH). This is registered and accounts for the same-cycle write and read.
- FIFO behaviour:
  - Write and read in the same cycle leave level unchanged.
  - A write with the FIFO full cannot occur, because s_frm_dr is low.
  - A read with the FIFO empty cannot occur, because m_frm_dv is low.
  - Pointers wrap modulo DEPTH and use an extra MSB to tell full from empty.
- Samples pass through bit-exact. There is no arithmetic or saturation.

## Timing
- Reset values: s_frm_dr=0, m_frm_dv=0, m_frm_d=0, level=0, ch_error=0, FSM=SYNC, exp_ch=0.
- s_frm_dr rises on the first clk edge after rst is deasserted.
- Latency: m_frm_dv and level update on the edge following the last-channel accept (1 cycle).
- m_frm_d and m_frm_dv are registered and are stable while m_frm_dv && !m_frm_dr.
- Back-to-back: with m_frm_dr=1, one frame per NR_CHANNELS input cycles is sustained with no bubbles.
- When the FIFO becomes full, s_frm_dr drops on the edge after the filling write. It rises on the edge after a read makes level < DEPTH.
- ch_error is high for exactly the cycle after the offending accept.
- rst asserted mid-frame or mid-burst: all state clears immediately. The partial frame and all buffered frames are lost.

## Structure
- Shared package intrp_pkg holds:
  - the CHW/LVLW computation function
  - the frame slot index helper
  - the SYNC/COLLECT enum typedef
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH; async active-high rst) contains storage, pointers and level.
- intrp_frame_fifo itself contains the assembly FSM and the staging register.

## Test plan
- Reset, then drive ch 0,1,2 with data 0x100001, 0x200002, 0x300003, m_frm_dr=1 → one cycle after ch2 is accepted: m_frm_dv=1, m_frm_d={0x300003,0x200002,0x100001}, level returns to 0.
- Hold m_frm_dr=0 and push 16 frames → level=16 and s_frm_dr=0. A further s_frm_dv is not accepted. Pop 1 frame → s_frm_dr=1 and data order is preserved.
- Sequence ch 0,1,0,1,2 → ch_error pulses once and exactly one frame is output, made from the last three samples.
- Sequence ch 1,2,0,1,2 after reset → the first two samples are discarded in SYNC, one frame is output, and ch_error stays 0.
- Random m_frm_dr at 50% with 1000 frames → output matches the scoreboard and there is no loss.
- Assert rst with 5 frames buffered and 2 samples staged → level=0, m_frm_dv=0, s_frm_dr=0 while in reset. The next full frame after release is output correctly.
